// File: rtl/sbus_ram_if.sv
// sbus_ram_if: simple-bus request/response bundle between a core master and a memory responder
interface sbus;
  logic [31:0] addr_;
  logic        enable;
  logic [3:0]  write_en;
  logic [31:0] data_w;
  logic [31:0] data_r;
  logic        stall;
  modport master(output addr_, enable, write_en, data_w, input data_r, stall);
  modport slave(input addr_, enable, write_en, data_w, output data_r, stall);
endinterface

// File: rtl/sbus_ram.sv
// sbus_ram: wait-state sbus responder over a word RAM; define SBUS_RAM_RANGE_CHECK_EN for address range checking
module sbus_ram #(
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic clk,
  input  logic rst,
  sbus.slave   bus,
  output logic err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;
  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   data_r_q;
  logic [31:0]   mem_q [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic          access, in_range, is_read;
  assign idx      = bus.addr_[AW+1:2];
  assign is_read  = bus.write_en == 4'h0;
  assign bus.stall  = bus.enable && state_q != DONE;
  assign bus.data_r = data_r_q;
`ifdef SBUS_RAM_RANGE_CHECK_EN
  logic err_q;
  logic unused_bits;
  // BASE_ADDR is aligned to the RAM size, so range membership is an upper-bit match
  assign in_range    = bus.addr_[31:AW+2] == BASE_ADDR[31:AW+2];
  assign err         = err_q;
  assign unused_bits = ^{bus.addr_[1:0], BASE_ADDR[AW+1:0]};
  always_ff @(posedge clk) err_q <= !rst && access && !in_range;
`else
  logic unused_bits;
  assign in_range    = 1'b1;
  assign err         = 1'b0;
  assign unused_bits = ^{bus.addr_[1:0], bus.addr_[31:AW+2], BASE_ADDR};
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    access  = 1'b0;
    case (state_q)
      IDLE: if (bus.enable) begin
        state_d = WAIT;
        cnt_d   = 4'(LATENCY);
      end
      WAIT: if (!bus.enable) state_d = IDLE;
        else if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else begin
          access  = 1'b1;
          state_d = DONE;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      data_r_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (access && is_read) data_r_q <= in_range ? mem_q[idx] : 32'h0;
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (!rst && access && in_range && bus.write_en[i]) mem_q[idx][8*i +: 8] <= bus.data_w[8*i +: 8];
  end
endmodule

// File: tb/tb_sbus_ram.sv
// tb_sbus_ram: randomized scoreboard bench for sbus_ram against a word-array reference model
module tb_sbus_ram;
  localparam int          DEPTH = 16;
  localparam int          LAT   = 2;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  typedef struct {
    logic        rd;
    logic [31:0] data;
    logic        err;
    int          start;
  } exp_t;
  logic clk = 0, rst = 1, err;
  logic [31:0] model [DEPTH];
  exp_t q[$];
  exp_t mon_e;
  int cyc = 0, checks = 0, passes = 0;
  sbus bus();
  sbus_ram #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .bus(bus), .err(err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  function automatic bit in_rng(logic [31:0] a);
`ifdef SBUS_RAM_RANGE_CHECK_EN
    return a >= BASE && a < BASE + 4 * DEPTH;
`else
    return 1'b1;
`endif
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act === want) passes++;
    else $display("FAIL %s: got %h want %h", name, act, want);
  endtask
  task automatic wait_done();
    bit ok = 0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      ok = !bus.stall;
    end
    if (!ok) begin
      checks++;
      $display("FAIL completion_timeout: got stall=1 want stall=0");
    end
  endtask
  task automatic present(logic [31:0] addr, logic [3:0] we, logic [31:0] wd);
    @(posedge clk); #1;
    bus.addr_ = addr; bus.write_en = we; bus.data_w = wd; bus.enable = 1'b1;
  endtask
  task automatic issue(logic [31:0] addr, logic [3:0] we, logic [31:0] wd);
    exp_t e;
    int w = int'((addr >> 2) % DEPTH);
    present(addr, we, wd);
    e.rd = we == 4'h0;
    e.start = cyc;
    e.err = !in_rng(addr);
    e.data = 32'h0;
    if (in_rng(addr)) begin
      if (e.rd) e.data = model[w];
      else for (int i = 0; i < 4; i++) if (we[i]) model[w][8*i +: 8] = wd[8*i +: 8];
    end
    q.push_back(e);
    wait_done();
  endtask
  task automatic idle(int n);
    @(posedge clk); #1;
    bus.enable = 1'b0; bus.write_en = 4'h0;
    repeat (n - 1) @(posedge clk);
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.enable && !bus.stall) begin
        if (q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_completion: got completion want none");
        end else begin
          mon_e = q.pop_front();
          chk("latency", cyc - mon_e.start, LAT + 2);
          chk("err_done", {31'h0, err}, {31'h0, mon_e.err});
          if (mon_e.rd) chk("rdata", bus.data_r, mon_e.data);
        end
      end else chk("err_quiet", {31'h0, err}, 32'h0);
    end
  end
  initial begin
    bus.enable = 0; bus.write_en = 0; bus.addr_ = 0; bus.data_w = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data_r", bus.data_r, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_stall_lo", {31'h0, bus.stall}, 32'h0);
    bus.enable = 1; #1;
    chk("rst_stall_hi", {31'h0, bus.stall}, 32'h1);
    bus.enable = 0;
    @(posedge clk); #1 rst = 0;
    for (int w = 0; w < DEPTH; w++) issue(BASE + 32'(4 * w), 4'hF, $urandom);
    idle(2);
    issue(BASE + 32'h10, 4'hF, 32'hDEADBEEF); idle(1);
    issue(BASE + 32'h10, 4'h0, 32'h0); idle(1);
    issue(BASE + 32'h10, 4'hF, 32'h11223344); idle(1);
    issue(BASE + 32'h10, 4'b0101, 32'hAABBCCDD); idle(1);
    issue(BASE + 32'h10, 4'h0, 32'h0); idle(1);
    issue(BASE + 32'h0, 4'h0, 32'h0);
    issue(BASE + 32'h4, 4'h0, 32'h0); idle(2);
    issue(BASE + 32'h40, 4'h0, 32'h0); idle(1);
    issue(BASE + 32'h44, 4'hF, 32'h0BADF00D); idle(1);
    issue(BASE + 32'h4, 4'h0, 32'h0); idle(1);
    issue(BASE + 32'h20, 4'hF, 32'h55555555); idle(1);
    present(BASE + 32'h20, 4'hF, 32'h0);
    @(posedge clk);
    @(posedge clk); #1 bus.enable = 0;
    #1 chk("abort_stall", {31'h0, bus.stall}, 32'h0);
    issue(BASE + 32'h20, 4'h0, 32'h0); idle(1);
    present(BASE + 32'h24, 4'hF, 32'h0);
    @(posedge clk);
    @(posedge clk); #1 rst = 1; bus.enable = 0;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("midrst_data_r", bus.data_r, 32'h0);
    chk("midrst_err", {31'h0, err}, 32'h0);
    issue(BASE + 32'h24, 4'h0, 32'h0); idle(1);
    for (int n = 0; n < 200; n++) begin
      logic [31:0] a = BASE - 32'h40 + 32'(4 * $urandom_range(0, 47)) + 32'($urandom_range(0, 3));
      logic [3:0] we = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      int gap = $urandom_range(0, 2);
      issue(a, we, $urandom);
      if (gap > 0) idle(gap);
    end
    idle(3);
    chk("drain", q.size(), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
